// File: rtl/calc_port_sequencer.sv
// Per-port front end for the four-port calculator: buffers (cmd, op1, op2) requests, serialises them
// onto the two-cycle command bus and returns the response. Define CALC_PORT_STATS_EN for event counters.
module calc_port_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  output logic [3:0]  calc_cmd,
  output logic [31:0] calc_data,
  input  logic [1:0]  calc_resp,
  input  logic [31:0] calc_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_resp,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        timeout_err
`ifdef CALC_PORT_STATS_EN
  ,
  output logic [15:0] stat_issued,
  output logic [15:0] stat_done,
  output logic [15:0] stat_timeout,
  output logic [15:0] stat_spurious
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEND_OP1, SEND_OP2, WAIT_RESP, HOLD_RESP} state_e;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
  } req_t;

  state_e        state_q, state_d;
  req_t          mem_q [FIFO_DEPTH];
  req_t          head;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          push, pop, empty, full_d, expire;

  logic [3:0]  calc_cmd_q, calc_cmd_d;
  logic [31:0] calc_data_q, calc_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        timeout_err_q, timeout_err_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    push    = req_valid && req_ready_q;
    head    = mem_q[rd_ptr_q[AW-1:0]];
    cnt_inc = cnt_q + 1'b1;
    expire  = (cnt_inc == CW'(TIMEOUT));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!empty && head.cmd != 4'd0) state_d = SEND_OP1;
      SEND_OP1:  state_d = SEND_OP2;
      SEND_OP2:  state_d = WAIT_RESP;
      WAIT_RESP: if (calc_resp != 2'd0 || expire) state_d = HOLD_RESP;
      HOLD_RESP: if (rsp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    calc_cmd_d    = calc_cmd_q;
    calc_data_d   = calc_data_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_data_d    = rsp_data_q;
    timeout_err_d = 1'b0;
    cnt_d         = cnt_q;
    pop           = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && head.cmd == 4'd0) begin
          pop = 1'b1;
        end else if (!empty) begin
          calc_cmd_d  = head.cmd;
          calc_data_d = head.op1;
        end
      end
      SEND_OP1: begin
        calc_cmd_d  = 4'd0;
        calc_data_d = head.op2;
        pop         = 1'b1;
      end
      SEND_OP2: begin
        calc_cmd_d  = 4'd0;
        calc_data_d = 32'd0;
        cnt_d       = '0;
      end
      WAIT_RESP: begin
        if (calc_resp != 2'd0) begin
          rsp_resp_d  = calc_resp;
          rsp_data_d  = calc_rdata;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (expire) begin
            rsp_resp_d    = 2'd3;
            rsp_data_d    = 32'd0;
            rsp_valid_d   = 1'b1;
            timeout_err_d = 1'b1;
          end
        end
      end
      HOLD_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
    full_d      = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    req_ready_d = !full_d;
    busy_d      = (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);
  end

  // NOTE: the FIFO storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge c_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{cmd: req_cmd, op1: req_op1, op2: req_op2};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      calc_cmd_q    <= 4'd0;
      calc_data_q   <= 32'd0;
      rsp_valid_q   <= 1'b0;
      rsp_resp_q    <= 2'd0;
      rsp_data_q    <= 32'd0;
      timeout_err_q <= 1'b0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      calc_cmd_q    <= calc_cmd_d;
      calc_data_q   <= calc_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_data_q    <= rsp_data_d;
      timeout_err_q <= timeout_err_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign calc_cmd    = calc_cmd_q;
  assign calc_data   = calc_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

`ifdef CALC_PORT_STATS_EN
  logic        issue, capture, spurious;
  logic [15:0] st_issued_q, st_done_q, st_timeout_q, st_spurious_q;

  function automatic logic [15:0] sat_inc(logic [15:0] v, logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  assign issue    = (state_q == IDLE) && (state_d == SEND_OP1);
  assign capture  = (state_q == WAIT_RESP) && (calc_resp != 2'd0);
  assign spurious = (state_q != WAIT_RESP) && (calc_resp != 2'd0);

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      st_issued_q   <= 16'd0;
      st_done_q     <= 16'd0;
      st_timeout_q  <= 16'd0;
      st_spurious_q <= 16'd0;
    end else begin
      st_issued_q   <= sat_inc(st_issued_q, issue);
      st_done_q     <= sat_inc(st_done_q, capture);
      st_timeout_q  <= sat_inc(st_timeout_q, timeout_err_d);
      st_spurious_q <= sat_inc(st_spurious_q, spurious);
    end
  end

  assign stat_issued   = st_issued_q;
  assign stat_done     = st_done_q;
  assign stat_timeout  = st_timeout_q;
  assign stat_spurious = st_spurious_q;
`endif

endmodule

// File: tb/tb_calc_port_sequencer.sv
// Bench for calc_port_sequencer: plays the calculator on the command bus and scores responses
// against an in-order transaction model (directed cases followed by a randomized run).
module tb_calc_port_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_cmd = 4'd0;
  logic [31:0] req_op1 = 32'd0;
  logic [31:0] req_op2 = 32'd0;
  logic [3:0]  calc_cmd;
  logic [31:0] calc_data;
  logic [1:0]  calc_resp = 2'd0;
  logic [31:0] calc_rdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic        busy;
  logic        timeout_err;
`ifdef CALC_PORT_STATS_EN
  logic [15:0] stat_issued, stat_done, stat_timeout, stat_spurious;
`endif

  calc_port_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .c_clk(c_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
    .calc_cmd(calc_cmd), .calc_data(calc_data),
    .calc_resp(calc_resp), .calc_rdata(calc_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_resp(rsp_resp), .rsp_data(rsp_data),
    .busy(busy), .timeout_err(timeout_err)
`ifdef CALC_PORT_STATS_EN
    , .stat_issued(stat_issued), .stat_done(stat_done),
    .stat_timeout(stat_timeout), .stat_spurious(stat_spurious)
`endif
  );

  always #5 c_clk = ~c_clk;

  // delay: cycles after op2 is on the bus until the calculator answers; 0 = never answers.
  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    int          delay;
    logic [1:0]  code;
  } txn_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          rise;
    bit          tmo;
  } exp_t;

  txn_t        pend[$];
  exp_t        expq[$];
  int          total = 0, bad = 0;
  int          cyc = 0, n_hs = 0, tmo_pulses = 0, exp_tmo = 0;
  int          respond_at = 0;
  logic [1:0]  respond_code = 2'd0;
  logic [31:0] respond_data = 32'd0;
  logic [1:0]  force_resp = 2'd0;
  bit          cap_phase = 0, rnd_ready = 0;
  bit          prev_valid = 0, prev_tmo = 0;
  logic [1:0]  prev_resp = 2'd0;
  logic [31:0] prev_data = 32'd0;

  function automatic logic [31:0] calc_ref(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    case (c)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance, score outputs, then act as the calculator for the next edge.
  task automatic step();
    bit   hs, was_ready;
    txn_t t;
    exp_t e;
    hs        = req_valid && req_ready;
    was_ready = rsp_ready;
    @(posedge c_clk);
    #1;
    cyc++;
    if (hs) n_hs++;

    if (rsp_valid && !prev_valid) begin
      check("rsp_pending", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("rsp_resp", rsp_resp, e.resp);
        check("rsp_data", rsp_data, e.data);
        check("rsp_cycle", cyc, e.rise);
        check("rsp_timeout_err", timeout_err, e.tmo);
        if (e.tmo) exp_tmo++;
      end
    end else if (prev_valid && !was_ready) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_resp", rsp_resp, prev_resp);
      check("hold_data", rsp_data, prev_data);
    end else if (prev_valid && was_ready) begin
      check("rsp_drop", rsp_valid, 0);
    end
    if (timeout_err) begin
      tmo_pulses++;
      check("tmo_one_cycle", prev_tmo, 0);
    end

    if (calc_cmd != 4'd0) begin
      check("bus_expected", pend.size() > 0, 1);
      if (pend.size() > 0) begin
        check("bus_cmd", calc_cmd, pend[0].cmd);
        check("bus_op1", calc_data, pend[0].op1);
      end
      cap_phase = 1;
    end else if (cap_phase) begin
      cap_phase = 0;
      if (pend.size() > 0) begin
        t = pend.pop_front();
        check("bus_op2", calc_data, t.op2);
        respond_code = t.code;
        respond_data = calc_ref(t.cmd, t.op1, t.op2);
        respond_at   = (t.delay == 0) ? 0 : cyc + t.delay;
        if (t.delay == 0 || t.delay > TMO + 1)
          expq.push_back('{resp: 2'd3, data: 32'd0, rise: cyc + TMO + 1, tmo: 1'b1});
        else
          expq.push_back('{resp: t.code, data: respond_data, rise: cyc + t.delay, tmo: 1'b0});
      end
    end

    if (force_resp != 2'd0)                          calc_resp = force_resp;
    else if (respond_at != 0 && cyc + 1 == respond_at) calc_resp = respond_code;
    else                                             calc_resp = 2'd0;
    calc_rdata = (calc_resp != 2'd0) ? respond_data : $urandom;
    if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));

    prev_valid = rsp_valid;
    prev_resp  = rsp_resp;
    prev_data  = rsp_data;
    prev_tmo   = timeout_err;
  endtask

  task automatic offer(logic [3:0] cmd, logic [31:0] op1, logic [31:0] op2, int delay, logic [1:0] code);
    if (cmd != 4'd0) pend.push_back('{cmd: cmd, op1: op1, op2: op2, delay: delay, code: code});
    req_cmd   = cmd;
    req_op1   = op1;
    req_op2   = op2;
    req_valid = 1'b1;
  endtask

  task automatic push(logic [3:0] cmd, logic [31:0] op1, logic [31:0] op2, int delay, logic [1:0] code);
    int start;
    start = n_hs;
    offer(cmd, op1, op2, delay, code);
    for (int i = 0; i < 500 && n_hs == start; i++) step();
    check("push_accept", n_hs - start, 1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    rnd_ready = 0;
    rsp_ready = 1'b1;
    done      = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      step();
      done = (pend.size() == 0) && (expq.size() == 0) && !busy && !rsp_valid;
    end
    check("drain_idle", done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int       hs0;
    logic [3:0] cmds [7];
    cmds[0] = 4'd0; cmds[1] = 4'd1; cmds[2] = 4'd2; cmds[3] = 4'd5;
    cmds[4] = 4'd6; cmds[5] = 4'd3; cmds[6] = 4'd7;

    // Reset values.
    #1 reset = 1'b0;
    #1;
    check("rst_calc_cmd", calc_cmd, 0);
    check("rst_calc_data", calc_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_resp", rsp_resp, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);
    step();
    step();
    reset = 1'b1;
    step();

    // Add with bus latency.
    rsp_ready = 1'b1;
    push(4'd1, 32'h5, 32'h3, 3, 2'd1);
    step();
    check("add_op1_cmd", calc_cmd, 1);
    check("add_op1_data", calc_data, 32'h5);
    step();
    check("add_op2_cmd", calc_cmd, 0);
    check("add_op2_data", calc_data, 32'h3);
    drain();

    // Timeout: calculator never answers.
    push(4'd2, 32'h10, 32'h1, 0, 2'd1);
    drain();
    check("tmo_pulse_count", tmo_pulses, 1);

    // No-op dropped, then shr under response backpressure.
    rsp_ready = 1'b0;
    push(4'd0, 32'hDEAD, 32'hBEEF, 0, 2'd0);
    push(4'd6, 32'h80, 32'h4, 3, 2'd1);
    for (int i = 0; i < 100 && !rsp_valid; i++) step();
    check("bp_valid", rsp_valid, 1);
    repeat (5) step();
    check("bp_valid_hold", rsp_valid, 1);
    check("bp_data_hold", rsp_data, 32'h8);
    rsp_ready = 1'b1;
    step();
    check("bp_release", rsp_valid, 0);
    drain();

    // FIFO full with responses held back.
    rsp_ready = 1'b0;
    push(4'd1, 32'h100, 32'h1, 3, 2'd1);
    for (int k = 0; k < 4; k++) push(4'd2, $urandom, $urandom, 2 + k, 2'd1);
    check("full_after5", req_ready, 0);
    hs0 = n_hs;
    offer(4'd5, $urandom, 32'h3, 4, 2'd2);
    repeat (4) step();
    check("full_stall", n_hs - hs0, 0);
    check("full_ready_low", req_ready, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 200 && n_hs == hs0; i++) step();
    check("full_6th_accept", n_hs - hs0, 1);
    req_valid = 1'b0;
    drain();

    // Randomized traffic, including timeouts and the real-vs-timeout boundary.
    rnd_ready = 1;
    for (int k = 0; k < 40; k++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 11));
      push(cmds[$urandom_range(0, 6)], $urandom, $urandom, d, 2'($urandom_range(1, 3)));
    end
    push(4'd1, $urandom, $urandom, TMO + 1, 2'd1);
    drain();

    // Reset in WAIT_RESP with two entries queued.
    push(4'd1, 32'hA, 32'hB, 0, 2'd1);
    push(4'd2, 32'hC, 32'hD, 3, 2'd1);
    push(4'd6, 32'hE, 32'hF, 3, 2'd1);
    for (int i = 0; i < 50 && pend.size() > 2; i++) step();
    step();
    step();
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_calc_cmd", calc_cmd, 0);
    check("mid_rst_calc_data", calc_data, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_data", rsp_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 1);
    pend.delete();
    expq.delete();
    respond_at = 0;
    cap_phase  = 0;
    prev_valid = 0;
    prev_tmo   = 0;
    step();
    reset = 1'b1;
    force_resp = 2'd1;
    step();
    step();
    force_resp = 2'd0;
    repeat (6) step();
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_calc_cmd", calc_cmd, 0);
    push(4'd1, 32'h7, 32'h9, 2, 2'd1);
    drain();

    check("tmo_pulses_total", tmo_pulses, exp_tmo);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
